// File: rtl/trisc_pkg.sv
// rtl/trisc_pkg.sv - shared opcode map, one-hot bit indices and encoder FSM states
// Purpose: single source of the instruction set encoding used by the encoder
//          and by the decoder.
// Ports:   none (package).
package trisc_pkg;

  localparam int OP_W = 11;

  // Position of each instruction in the one-hot request vector.
  localparam int BIT_LDA = 10;
  localparam int BIT_STA = 9;
  localparam int BIT_ADD = 8;
  localparam int BIT_SUB = 7;
  localparam int BIT_XOR = 6;
  localparam int BIT_INC = 5;
  localparam int BIT_CLR = 4;
  localparam int BIT_JMP = 3;
  localparam int BIT_JPZ = 2;
  localparam int BIT_JPN = 1;
  localparam int BIT_HLT = 0;

  localparam logic [3:0] OPC_LDA = 4'b0000;
  localparam logic [3:0] OPC_STA = 4'b0001;
  localparam logic [3:0] OPC_ADD = 4'b0010;
  localparam logic [3:0] OPC_SUB = 4'b0011;
  localparam logic [3:0] OPC_XOR = 4'b0100;
  localparam logic [3:0] OPC_INC = 4'b0110;
  localparam logic [3:0] OPC_CLR = 4'b0111;
  localparam logic [3:0] OPC_JMP = 4'b1000;
  localparam logic [3:0] OPC_JPZ = 4'b1100;
  localparam logic [3:0] OPC_JPN = 4'b1001;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  function automatic logic [3:0] opcode_of_bit(input int idx);
    logic [3:0] opc;
    case (idx)
      BIT_LDA: opc = OPC_LDA;
      BIT_STA: opc = OPC_STA;
      BIT_ADD: opc = OPC_ADD;
      BIT_SUB: opc = OPC_SUB;
      BIT_XOR: opc = OPC_XOR;
      BIT_INC: opc = OPC_INC;
      BIT_CLR: opc = OPC_CLR;
      BIT_JMP: opc = OPC_JMP;
      BIT_JPZ: opc = OPC_JPZ;
      BIT_JPN: opc = OPC_JPN;
      BIT_HLT: opc = OPC_HLT;
      default: opc = OPC_LDA;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/onehot_to_opcode.sv
// rtl/onehot_to_opcode.sv - combinational one-hot request to 4-bit opcode converter
// Purpose: map the one-hot instruction request to its opcode and flag whether
//          exactly one request bit is set.
// Ports:   op_i     [10:0] one-hot request (LDA at bit 10 .. HLT at bit 0)
//          opcode_o [3:0]  opcode of the set bit (don't-care when !valid_o)
//          valid_o         exactly one bit of op_i is set
module onehot_to_opcode
  import trisc_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output logic [3:0]      opcode_o,
  output logic            valid_o
);

  always_comb begin
    opcode_o = OPC_LDA;
    for (int i = 0; i < OP_W; i++) begin
      if (op_i[i]) opcode_o = opcode_of_bit(i);
    end
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    valid_o = (op_i != '0) && ((op_i & (op_i - 11'd1)) == '0);
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - loads a program into memory from one-hot instruction requests
// Purpose: accept instructions while in LOAD, encode them as {opcode, operand}
//          and write them to sequential program-memory addresses with a
//          request/acknowledge handshake until HLT is written or DEPTH words
//          are stored.
// Option:  INSTR_ENCODER_CHECKSUM_EN adds the chksum output (XOR of all
//          acknowledged words since start/reset).
// Ports:   clk, reset_n          clock, asynchronous active-low reset
//          start                 abort and restart loading at address 0
//          in_valid / in_ready   instruction handshake
//          op [10:0], operand    one-hot instruction and 4-bit address field
//          mem_we / mem_ack      write request held until acknowledged
//          mem_addr, mem_wdata   write address (pointer) and encoded word
//          done, err, count      load finished, sticky bad-op, words written
//          chksum                (optional) running XOR of written words
module instr_encoder
  import trisc_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [3:0]      operand,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic [3:0]      mem_addr,
  output logic [7:0]      mem_wdata,
  output logic            done,
  output logic            err,
  output logic [4:0]      count
`ifdef INSTR_ENCODER_CHECKSUM_EN
  ,
  output logic [7:0]      chksum
`endif
);

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  enc_state_e  state_q;
  logic        in_ready_q;
  logic        mem_we_q;
  logic [3:0]  ptr_q;
  logic [7:0]  wdata_q;
  logic        done_q;
  logic        err_q;
  logic [4:0]  count_q;

  logic [3:0]  ptr_d;
  logic [4:0]  count_d;
  logic        last_d;
  logic [3:0]  opcode;
  logic        op_valid;

  onehot_to_opcode u_onehot_to_opcode (
    .op_i     (op),
    .opcode_o (opcode),
    .valid_o  (op_valid)
  );

  // Only HLT encodes to 4'b1111, so the latched word identifies it.
  assign ptr_d   = ptr_q + 4'd1;
  assign count_d = count_q + 5'd1;
  assign last_d  = (wdata_q[7:4] == OPC_HLT) || (count_d == DEPTH_C);

`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [7:0] chksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chksum_q <= 8'h00;
    end else if (start) begin
      chksum_q <= 8'h00;
    end else if (state_q == ST_WRITE && mem_ack) begin
      chksum_q <= chksum_q ^ wdata_q;
    end
  end

  assign chksum = chksum_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      ptr_q      <= 4'd0;
      wdata_q    <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= 5'd0;
    end else if (start) begin
      // Abort from any state: an outstanding write is abandoned.
      state_q    <= ST_LOAD;
      in_ready_q <= 1'b1;
      mem_we_q   <= 1'b0;
      ptr_q      <= 4'd0;
      wdata_q    <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b0;
        end
        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            if (op_valid) begin
              wdata_q    <= {opcode, operand};
              mem_we_q   <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= ST_WRITE;
            end else begin
              // Malformed request is dropped; stay ready for the next one.
              err_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_we_q <= 1'b0;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            if (last_d) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_LOAD;
              in_ready_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          in_ready_q <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          mem_we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = ptr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

  localparam int DEPTH = 4;

  localparam logic [10:0] R_LDA = 11'b100_0000_0000;
  localparam logic [10:0] R_STA = 11'b010_0000_0000;
  localparam logic [10:0] R_ADD = 11'b001_0000_0000;
  localparam logic [10:0] R_INC = 11'b000_0010_0000;
  localparam logic [10:0] R_JPZ = 11'b000_0000_0100;
  localparam logic [10:0] R_HLT = 11'b000_0000_0001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] op;
  logic [3:0]  operand;
  logic        mem_we;
  logic        mem_ack;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        done;
  logic        err;
  logic [4:0]  count;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [7:0]  chksum;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  logic [3:0]  exp_ptr;
  int          held;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .err       (err),
    .count     (count)
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    .chksum    (chksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_in_ready"},  32'(in_ready),  32'd0);
    chk({pfx, "_mem_we"},    32'(mem_we),    32'd0);
    chk({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({pfx, "_done"},      32'(done),      32'd0);
    chk({pfx, "_err"},       32'(err),       32'd0);
    chk({pfx, "_count"},     32'(count),     32'd0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk({pfx, "_chksum"},    32'(chksum),    32'd0);
`endif
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    exp_ptr = 4'd0;
  endtask

  // Present one well-formed instruction, then acknowledge the write
  // ack_delay cycles after mem_we rises (0 = same cycle).
  task automatic send(input logic [10:0] o, input logic [3:0] a, input logic [7:0] w,
                      input int ack_delay, output int we_cycles);
    int          n;
    logic [11:0] e;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = o;
    operand  = a;
    exp_q.push_back({exp_ptr, w});
    @(posedge clk); #1;
    in_valid  = 1'b0;
    op        = '0;
    operand   = '0;
    we_cycles = 0;
    for (int c = 0; c <= ack_delay; c++) begin
      if (c == ack_delay) mem_ack = 1'b1;
      @(negedge clk);
      if (mem_we) we_cycles++;
      if (c == ack_delay) begin
        e = exp_q.pop_front();
        chk("wr_addr",  32'(mem_addr),  32'(e[11:8]));
        chk("wr_wdata", 32'(mem_wdata), 32'(e[7:0]));
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    exp_ptr = exp_ptr + 4'd1;
  endtask

  task automatic drop(input logic [10:0] o);
    in_valid = 1'b1;
    op       = o;
    @(negedge clk);
    chk("drop_no_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = '0;
    @(negedge clk);
    chk("drop_no_we_after", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    op       = '0;
    operand  = '0;
    mem_ack  = 1'b0;
    exp_ptr  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Single LDA 5, ack on the third cycle of mem_we.
    do_start();
    chk("start_in_ready", 32'(in_ready), 32'd1);
    send(R_LDA, 4'd5, 8'h05, 2, held);
    chk("lda_we_held", 32'(held), 32'd3);
    chk("lda_count", 32'(count), 32'd1);
    chk("lda_back_to_load", 32'(in_ready), 32'd1);

    // ADD 3, JPZ 7, HLT 0 with same-cycle acks.
    do_start();
    chk("restart_count", 32'(count), 32'd0);
    send(R_ADD, 4'd3, 8'h23, 0, held);
    chk("imm_we_held", 32'(held), 32'd1);
    send(R_JPZ, 4'd7, 8'hC7, 0, held);
    send(R_HLT, 4'd0, 8'hF0, 0, held);
    chk("prog_done", 32'(done), 32'd1);
    chk("prog_in_ready", 32'(in_ready), 32'd0);
    chk("prog_count", 32'(count), 32'd3);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk("prog_chksum", 32'(chksum), 32'h14);
`endif

    // Malformed requests are dropped and flag err.
    do_start();
    chk("start_clears_done", 32'(done), 32'd0);
    drop(11'd0);
    chk("zero_op_err", 32'(err), 32'd1);
    chk("zero_op_count", 32'(count), 32'd0);
    drop(R_LDA | R_STA);
    chk("multi_op_err", 32'(err), 32'd1);
    chk("multi_op_count", 32'(count), 32'd0);
    chk("multi_op_ready", 32'(in_ready), 32'd1);
    send(R_LDA, 4'd1, 8'h01, 1, held);
    chk("after_err_count", 32'(count), 32'd1);
    chk("err_sticky", 32'(err), 32'd1);

    // Fill to DEPTH with INC words.
    do_start();
    chk("start_clears_err", 32'(err), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      send(R_INC, 4'(i + 8), {4'h6, 4'(i + 8)}, i % 2, held);
      chk("full_done_flag", 32'(done), (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    chk("full_count", 32'(count), 32'(DEPTH));
    in_valid = 1'b1;
    op       = R_LDA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ignore_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    op       = '0;
    chk("full_ignore_count", 32'(count), 32'(DEPTH));
    chk("full_still_done", 32'(done), 32'd1);

    // Reset in the middle of a write.
    do_start();
    in_valid = 1'b1;
    op       = R_LDA;
    operand  = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = '0;
    operand  = '0;
    chk("pre_reset_we", 32'(mem_we), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("midwr_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(in_ready), 32'd0);

    // start in the middle of a write.
    do_start();
    send(R_STA, 4'd4, 8'h14, 0, held);
    in_valid = 1'b1;
    op       = R_LDA;
    operand  = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = '0;
    operand  = '0;
    chk("pre_abort_we", 32'(mem_we), 32'd1);
    chk("pre_abort_addr", 32'(mem_addr), 32'd1);
    do_start();
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);

    // Stray ack while loading changes nothing.
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stray_ack_count", 32'(count), 32'd0);
    chk("stray_ack_we", 32'(mem_we), 32'd0);
    send(R_LDA, 4'd3, 8'h03, 0, held);
    chk("after_abort_count", 32'(count), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 16, the number of program words writable before full (1..16).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle pulse; clears pointer and flags, enters LOAD.
REQ-006 in_valid  input  1  producer has an instruction.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 op  input  11  one-hot request, bit10..bit0 = LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT.
REQ-009 operand  input  4  address field of the instruction.
REQ-010 mem_we  output  1  program-memory write request, held until acknowledged.
REQ-011 mem_ack  input  1  memory has taken the write.
REQ-012 mem_addr  output  4  write address.
REQ-013 mem_wdata  output  8  {opcode[3:0], operand[3:0]}.
REQ-014 done  output  1  load finished (HLT written or full).
REQ-015 err  output  1  sticky: non-one-hot op seen.
REQ-016 count  output  5  words written since start.

Function
REQ-017 Opcode map SHALL be LDA 0000, STA 0001, ADD 0010, SUB 0011, XOR 0100, INC 0110, CLR 0111, JMP 1000, JPZ 1100, JPN 1001, HLT 1111.
REQ-018 FSM states SHALL be IDLE, LOAD, WRITE, DONE.
REQ-019 IDLE: in_ready=0; start -> LOAD.
REQ-020 LOAD: in_ready=1; in_valid&in_ready with one-hot op -> latch word, go WRITE; mem_we asserts the next cycle.
REQ-021 A non-one-hot op (zero or >1 bit) accepted in LOAD SHALL set err, be dropped, and leave the FSM in LOAD with pointer unchanged.
REQ-022 WRITE: in_ready=0; mem_we, mem_addr, mem_wdata SHALL stay stable until the cycle mem_ack=1.
REQ-023 On mem_ack, pointer and count SHALL increment; if the word was HLT or count reaches DEPTH -> DONE, else -> LOAD.
REQ-024 mem_ack asserted in the same cycle mem_we first rises SHALL complete the write (minimum 2 cycles per instruction).
REQ-025 mem_ack outside WRITE SHALL be ignored.
REQ-026 DONE: done=1, in_ready=0; only start leaves it (-> LOAD).
REQ-027 start in any state SHALL abort: mem_we drops next cycle, pointer=0, count=0, err=0, done=0, state LOAD.
REQ-028 mem_addr SHALL equal the pointer; the pointer never wraps because DEPTH<=16 forces DONE first.

Reset
REQ-029 Reset SHALL force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, count=0.
REQ-030 Reset mid-WRITE SHALL drop mem_we immediately and not write the word.

Configuration
REQ-031 With INSTR_ENCODER_CHECKSUM_EN defined, an 8-bit output chksum SHALL hold the XOR of all acknowledged mem_wdata since start/reset (0 after either).
REQ-032 Without INSTR_ENCODER_CHECKSUM_EN, the chksum port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Opcode constants, one-hot bit indices, and the FSM state encoding SHALL live in shared package trisc_pkg, also used by the decoder.
REQ-034 The one-hot-to-opcode conversion with a valid flag SHALL be sub-module onehot_to_opcode (combinational).

Verification
REQ-035 start; op=LDA, operand=5; mem_ack after 3 cycles -> mem_we held 3 cycles, mem_addr=0, mem_wdata=0x05, count=1.
REQ-036 Program ADD 3, JPZ 7, HLT 0 with immediate acks -> words 0x23, 0xC7, 0xF0 at addresses 0..2; done=1; in_ready=0.
REQ-037 op=0 and then op=LDA|STA -> err=1, no mem_we, count unchanged; next valid LDA 1 is written at address 0.
REQ-038 DEPTH=4, four INC words -> addresses 0..3 written, done=1 after fourth ack, in_valid afterwards ignored.
REQ-039 reset_n low while mem_we=1 -> mem_we=0 the same cycle, all outputs at reset values; start mid-WRITE -> mem_we=0 next cycle, count=0.
REQ-040 With INSTR_ENCODER_CHECKSUM_EN: words 0x23, 0xC7, 0xF0 -> chksum=0x14.
